// File: rtl/serial_frame_rx_pkg.sv
// Shared definitions for the serial frame receiver: state encodings, line
// levels and the registered pulse bundle.
package serial_frame_rx_pkg;

   // FSM state encodings (kept identical to the matching transmitter)
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_PAR  = 2'd2;
   localparam logic [1:0] S_STOP = 2'd3;

   // Line levels
   localparam logic IDLE_LVL  = 1'b1;
   localparam logic START_LVL = 1'b0;

   // One-cycle status pulses; at most one field is set in any cycle
   typedef struct packed {
      logic valid;
      logic frame_err;
      logic parity_err;
   } rx_pulse_t;

endpackage

// File: rtl/serial_frame_rx_if.sv
// Bus between a serial source and the frame receiver. The source drives d
// one bit per rising clk edge; the receiver returns the rebuilt word and
// one-cycle status pulses (no backpressure: a pulse is seen exactly once).
interface serial_frame_rx_if #(
   parameter int WIDTH = 8
);
   logic             d;
   logic [WIDTH-1:0] q;
   logic             valid;
   logic             frame_err;
   logic             parity_err;
   logic [1:0]       dbg_state;

   modport master (
      output d,
      input  q, valid, frame_err, parity_err, dbg_state
   );

   modport slave (
      input  d,
      output q, valid, frame_err, parity_err, dbg_state
   );
endinterface

// File: rtl/serial_frame_rx_shift_in.sv
// Enable-gated right shifter: each enabled edge pushes d into the MSB, so a
// LSB-first serial word ends up aligned after WIDTH enabled edges.
module shift_in #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             d,
   output logic [WIDTH-1:0] word
);

   logic [WIDTH-1:0] r_word;

   // Shift in one bit from the top on every enabled edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
      end else if (en) begin
         r_word <= {d, r_word[WIDTH-1:1]};
      end
   end

   assign word = r_word;

endmodule

// File: rtl/serial_frame_rx.sv
// Framed serial receiver: start bit (0), WIDTH data bits LSB first, optional
// even-parity bit, stop bit (1). Rebuilds the parallel word and reports
// good word / frame error / parity error as registered one-cycle pulses.
module serial_frame_rx
   import serial_frame_rx_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit PARITY_EN = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   serial_frame_rx_if.slave   bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   logic [1:0]       r_state;
   logic [CW-1:0]    r_cnt;
   logic             r_par_bad;
   logic [WIDTH-1:0] r_q;
   rx_pulse_t        r_pulse;

   logic             w_shift_en;
   logic             w_last_bit;
   logic [WIDTH-1:0] w_word;

   assign w_shift_en = (r_state == S_DATA);
   assign w_last_bit = (r_cnt == LAST_BIT);

   shift_in #(.WIDTH(WIDTH)) u_shift_in (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (w_shift_en),
      .d     (bus.d),
      .word  (w_word)
   );

   // Frame FSM with data bit counter and parity tracking
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_par_bad <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.d == START_LVL) begin
                  r_state   <= S_DATA;
                  r_cnt     <= '0;
                  r_par_bad <= 1'b0;
               end
            end
            S_DATA: begin
               // Counter stops at the last data bit and never wraps past it
               if (w_last_bit) begin
                  r_cnt   <= '0;
                  r_state <= PARITY_EN ? S_PAR : S_STOP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            S_PAR: begin
               // Even parity: data ones plus parity bit must be even
               r_par_bad <= (^w_word) ^ bus.d;
               r_state   <= S_STOP;
            end
            S_STOP: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Stop-bit evaluation: update word or raise exactly one error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pulse <= '0;
         r_q     <= '0;
      end else begin
         r_pulse <= '0;
         if (r_state == S_STOP) begin
            if (bus.d == IDLE_LVL) begin
               if (r_par_bad) begin
                  r_pulse.parity_err <= 1'b1;
               end else begin
                  r_pulse.valid <= 1'b1;
                  r_q           <= w_word;
               end
            end else begin
               // A broken stop bit wins over any parity result
               r_pulse.frame_err <= 1'b1;
            end
         end
      end
   end

   assign bus.q          = r_q;
   assign bus.valid      = r_pulse.valid;
   assign bus.frame_err  = r_pulse.frame_err;
   assign bus.parity_err = PARITY_EN ? r_pulse.parity_err : 1'b0;
   assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Bench for serial_frame_rx: one receiver without parity (dut0) and one with
// even parity (dut1), both WIDTH=8, clock period 200.
module tb_serial_frame_rx;

   localparam logic [1:0] K_VALID = 2'd1;
   localparam logic [1:0] K_FERR  = 2'd2;
   localparam logic [1:0] K_PERR  = 2'd3;

   typedef struct {
      int         dut;
      logic [7:0] data;
      logic       par;
      logic       stop;
      logic [1:0] kind;
      logic [7:0] exp_q;
      int         gap;
   } vec_t;

   logic clk = 1'b1;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   logic [9:0] exp_q0[$];
   logic [9:0] exp_q1[$];
   int         exp_c0[$];
   int         exp_c1[$];

   logic [7:0] model_q0 = 8'h00;
   logic [7:0] model_q1 = 8'h00;

   vec_t vecs[12];

   serial_frame_rx_if #(.WIDTH(8)) bus0 ();
   serial_frame_rx_if #(.WIDTH(8)) bus1 ();

   serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   serial_frame_rx #(.WIDTH(8), .PARITY_EN(1'b1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   // Clock and cycle count
   always #100 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Driver tasks: d changes in the middle of the low clock phase
   task automatic drive_bit(input int id, input logic b);
      @(negedge clk);
      #50;
      if (id == 0) bus0.d = b;
      else         bus1.d = b;
   endtask

   task automatic idle(input int id, input int n);
      for (int i = 0; i < n; i++) drive_bit(id, 1'b1);
   endtask

   task automatic send_frame(input int id, input logic [7:0] data, input logic par,
                             input logic stop);
      drive_bit(id, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(id, data[i]);
      if (id == 1) drive_bit(id, par);
      drive_bit(id, stop);
   endtask

   // Called right after the stop bit is driven: the pulse must be visible
   // after the next rising edge
   task automatic expect_pulse(input int id, input logic [1:0] kind, input logic [7:0] q);
      if (id == 0) begin
         exp_q0.push_back({kind, q});
         exp_c0.push_back(cyc + 1);
         if (kind == K_VALID) model_q0 = q;
      end else begin
         exp_q1.push_back({kind, q});
         exp_c1.push_back(cyc + 1);
         if (kind == K_VALID) model_q1 = q;
      end
   endtask

   // Scoreboard side: compare every observed pulse against the queue head
   task automatic mon(input int id, input logic v, input logic fe, input logic pe,
                      input logic [7:0] q);
      logic [9:0] act;
      logic [9:0] exp;
      int         ec;
      if (!(v | fe | pe)) return;
      check($sformatf("excl%0d", id), 32'($countones({v, fe, pe})), 32'd1);
      act = {(v ? K_VALID : (fe ? K_FERR : K_PERR)), q};
      if ((id == 0 && exp_q0.size() == 0) || (id == 1 && exp_q1.size() == 0)) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_pulse%0d: got %0h expected none (t=%0t)", id, act, $time);
         return;
      end
      if (id == 0) begin
         exp = exp_q0.pop_front();
         ec  = exp_c0.pop_front();
      end else begin
         exp = exp_q1.pop_front();
         ec  = exp_c1.pop_front();
      end
      check($sformatf("pulse%0d", id), 32'(act), 32'(exp));
      check($sformatf("latency%0d", id), 32'(cyc), 32'(ec));
   endtask

   always @(negedge clk) begin
      mon(0, bus0.valid, bus0.frame_err, bus0.parity_err, bus0.q);
      mon(1, bus1.valid, bus1.frame_err, bus1.parity_err, bus1.q);
   end

   initial begin
      logic [7:0] data;
      logic       stop;
      logic       par;
      logic [1:0] kind;
      logic [7:0] eq;
      int         gap;

      bus0.d = 1'b1;
      bus1.d = 1'b1;

      vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, K_VALID, 8'hA5, 3};
      vecs[1]  = '{0, 8'h3C, 1'b0, 1'b1, K_VALID, 8'h3C, 0};
      vecs[2]  = '{0, 8'hFF, 1'b0, 1'b1, K_VALID, 8'hFF, 0};
      vecs[3]  = '{0, 8'h81, 1'b0, 1'b0, K_FERR,  8'hFF, 0};
      vecs[4]  = '{0, 8'h12, 1'b0, 1'b1, K_VALID, 8'h12, 3};
      vecs[5]  = '{1, 8'h07, 1'b1, 1'b1, K_VALID, 8'h07, 1};
      vecs[6]  = '{1, 8'h07, 1'b0, 1'b1, K_PERR,  8'h07, 0};
      vecs[7]  = '{1, 8'h30, 1'b0, 1'b1, K_VALID, 8'h30, 0};
      vecs[8]  = '{1, 8'h31, 1'b0, 1'b1, K_PERR,  8'h30, 0};
      vecs[9]  = '{1, 8'h55, 1'b0, 1'b0, K_FERR,  8'h30, 0};
      vecs[10] = '{1, 8'h01, 1'b0, 1'b0, K_FERR,  8'h30, 0};
      vecs[11] = '{1, 8'hFE, 1'b1, 1'b1, K_VALID, 8'hFE, 2};

      // Reset state
      #1;
      check("rst_q0", 32'(bus0.q), 32'h00);
      check("rst_q1", 32'(bus1.q), 32'h00);
      check("rst_pulses0", 32'({bus0.valid, bus0.frame_err, bus0.parity_err}), 32'd0);
      check("rst_pulses1", 32'({bus1.valid, bus1.frame_err, bus1.parity_err}), 32'd0);
      check("rst_state0", 32'(bus0.dbg_state), 32'd0);
      check("rst_state1", 32'(bus1.dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      #50 rst_n = 1'b1;

      // Idle line must produce nothing
      idle(0, 20);
      check("idle_q0", 32'(bus0.q), 32'h00);
      check("idle_state0", 32'(bus0.dbg_state), 32'd0);

      // Table-driven frames
      for (int i = 0; i < 12; i++) begin
         send_frame(vecs[i].dut, vecs[i].data, vecs[i].par, vecs[i].stop);
         expect_pulse(vecs[i].dut, vecs[i].kind, vecs[i].exp_q);
         idle(vecs[i].dut, vecs[i].gap);
      end
      check("hold_q0", 32'(bus0.q), 32'h12);
      check("hold_q1", 32'(bus1.q), 32'hFE);

      // Reset in the middle of a frame: start + 4 data bits of 8'hF0
      drive_bit(0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(0, 1'b0);
      @(negedge clk);
      #50 rst_n = 1'b0;
      bus0.d = 1'b1;
      #10;
      check("midrst_q0", 32'(bus0.q), 32'h00);
      check("midrst_q1", 32'(bus1.q), 32'h00);
      check("midrst_state0", 32'(bus0.dbg_state), 32'd0);
      model_q0 = 8'h00;
      model_q1 = 8'h00;
      @(negedge clk);
      #50 rst_n = 1'b1;
      idle(0, 2);
      send_frame(0, 8'h5A, 1'b0, 1'b1);
      expect_pulse(0, K_VALID, 8'h5A);
      idle(0, 2);
      check("post_rst_q0", 32'(bus0.q), 32'h5A);

      // Random frames against the bench model
      for (int id = 0; id < 2; id++) begin
         for (int k = 0; k < 12; k++) begin
            data = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 3) != 0);
            par  = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 2);
            if (!stop)                           kind = K_FERR;
            else if (id == 1 && (par ^ (^data))) kind = K_PERR;
            else                                 kind = K_VALID;
            eq = (kind == K_VALID) ? data : ((id == 0) ? model_q0 : model_q1);
            send_frame(id, data, par, stop);
            expect_pulse(id, kind, eq);
            idle(id, gap);
         end
      end

      // Every expected pulse must have been seen
      idle(0, 4);
      check("drain0", 32'(exp_q0.size()), 32'd0);
      check("drain1", 32'(exp_q1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
